// File: rtl/demux1to4_reg_if.sv
// demux1to4_reg_if: producer/consumer bus of the registered 1-to-4 distributor
interface demux1to4_reg_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] In;
    logic [1:0]       Sel;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Out1;
    logic [WIDTH-1:0] Out2;
    logic [WIDTH-1:0] Out3;
    logic [WIDTH-1:0] Out4;
    logic [3:0]       OutValid;
    logic [3:0]       OutAck;
    logic             Ovf;
    modport master (
        output In, Sel, InValid, OutAck,
        input  InReady, Out1, Out2, Out3, Out4, OutValid, Ovf
    );
    modport slave (
        input  In, Sel, InValid, OutAck,
        output InReady, Out1, Out2, Out3, Out4, OutValid, Ovf
    );
endinterface

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: steers one word into one of four valid/ack holding slots; DEMUX_OVERWRITE_EN enables overwrite with sticky Ovf
module demux1to4_reg #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    demux1to4_reg_if.slave  bus
);
    logic [3:0]       r_valid;
    logic [3:0]       w_valid_next;
    logic [3:0]       w_load;
    logic [WIDTH-1:0] r_data [4];
    logic             w_ready;
    logic             w_accept;
    logic             w_ovf;
    // readiness of the addressed slot and the one-hot slot loaded this edge
    always_comb begin
`ifdef DEMUX_OVERWRITE_EN
        w_ready = 1'b1;
`else
        w_ready = ~r_valid[bus.Sel] | bus.OutAck[bus.Sel];
`endif
        w_accept = bus.InValid & w_ready;
        w_load = w_accept ? (4'b0001 << bus.Sel) : 4'b0000;
    end
    // per-slot next state: a load fills, an ack without load empties, otherwise hold
    always_comb w_valid_next = w_load | (r_valid & ~bus.OutAck);
    // per-slot state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_valid <= 4'b0000;
        else r_valid <= w_valid_next;
    end
    // slot data registers keep their word after consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_data[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (w_load[i]) r_data[i] <= bus.In;
        end
    end
`ifdef DEMUX_OVERWRITE_EN
    logic r_ovf;
    // sticky flag: a load into a full slot that is not being acked loses a word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ovf <= 1'b0;
        else r_ovf <= r_ovf | (|(w_load & r_valid & ~bus.OutAck));
    end
    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif
    // drive the bus outputs
    always_comb begin
        bus.InReady  = w_ready;
        bus.OutValid = r_valid;
        bus.Out1     = r_data[0];
        bus.Out2     = r_data[1];
        bus.Out3     = r_data[2];
        bus.Out4     = r_data[3];
        bus.Ovf      = w_ovf;
    end
endmodule

// File: tb/tb_demux1to4_reg.sv
// tb_demux1to4_reg: directed table-driven bench for demux1to4_reg
module tb_demux1to4_reg;
`ifdef DEMUX_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif
    typedef struct packed {
        logic [31:0]  din;
        logic [1:0]   sel;
        logic         inv;
        logic [3:0]   ack;
        logic         rdy;
        logic [3:0]   vld;
        logic [127:0] outs;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tv [18];

    demux1to4_reg_if #(.WIDTH(32)) bus ();
    demux1to4_reg #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] outs();
        return {bus.Out4, bus.Out3, bus.Out2, bus.Out1};
    endfunction

    initial begin
        logic        p_pend;
        logic [31:0] p_din;
        logic [1:0]  p_sel;
        checks = 0;
        errors = 0;
        p_pend = 1'b0;
        p_din = '0;
        p_sel = '0;
        tv[0]  = '{32'hDEADBEEF, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, {32'd0, 32'hDEADBEEF, 32'd0, 32'd0}};
        tv[1]  = '{32'h0,        2'd2, 1'b0, 4'b0100, 1'b1, 4'b0000, {32'd0, 32'hDEADBEEF, 32'd0, 32'd0}};
        tv[2]  = '{32'd7,        2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, {32'd0, 32'hDEADBEEF, 32'd0, 32'd7}};
        for (int i = 3; i < 8; i++)
            tv[i] = '{32'd1, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0001, {32'd0, 32'hDEADBEEF, 32'd0, 32'd7}};
        tv[8]  = '{32'd1,  2'd0, 1'b1, 4'b0001, 1'b1, 4'b0001, {32'd0,  32'hDEADBEEF, 32'd0,  32'd1}};
        tv[9]  = '{32'd10, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, {32'd0,  32'hDEADBEEF, 32'd0,  32'd10}};
        tv[10] = '{32'd11, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, {32'd0,  32'hDEADBEEF, 32'd11, 32'd10}};
        tv[11] = '{32'd12, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, {32'd0,  32'd12, 32'd11, 32'd10}};
        tv[12] = '{32'd13, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, {32'd13, 32'd12, 32'd11, 32'd10}};
        tv[13] = '{32'd20, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b1001, {32'd13, 32'd12, 32'd11, 32'd20}};
        tv[14] = '{32'd21, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b1011, {32'd13, 32'd12, 32'd21, 32'd20}};
        tv[15] = '{32'd22, 2'd2, 1'b1, 4'b1001, 1'b1, 4'b0110, {32'd13, 32'd22, 32'd21, 32'd20}};
        tv[16] = '{32'd23, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0111, {32'd13, 32'd22, 32'd21, 32'd23}};
        tv[17] = '{32'd24, 2'd3, 1'b1, 4'b0100, 1'b1, 4'b1011, {32'd24, 32'd22, 32'd21, 32'd23}};

        bus.In = '0;
        bus.Sel = '0;
        bus.InValid = 1'b0;
        bus.OutAck = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_valid", 128'(bus.OutValid), 128'(4'b0000));
        chk("reset_outs", outs(), 128'd0);
        chk("reset_ovf", 128'(bus.Ovf), 128'd0);
        for (int s = 0; s < 4; s++) begin
            bus.Sel = 2'(s);
            #1;
            chk($sformatf("reset_ready_sel%0d", s), 128'(bus.InReady), 128'd1);
        end

`ifndef DEMUX_OVERWRITE_EN
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (p_pend && (!tv[i].inv || tv[i].din != p_din || tv[i].sel != p_sel)) begin
                errors++;
                $display("PROTOCOL violation vec %0d: offer changed before accept", i);
            end
            bus.In = tv[i].din;
            bus.Sel = tv[i].sel;
            bus.InValid = tv[i].inv;
            bus.OutAck = tv[i].ack;
            #1;
            chk($sformatf("v%0d_ready", i), 128'(bus.InReady), 128'(tv[i].rdy));
            p_pend = tv[i].inv & ~tv[i].rdy;
            p_din = tv[i].din;
            p_sel = tv[i].sel;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 128'(bus.OutValid), 128'(tv[i].vld));
            chk($sformatf("v%0d_outs", i), outs(), tv[i].outs);
        end
        @(negedge clk);
        bus.InValid = 1'b0;
        bus.OutAck = '0;
        chk("pre_reset_valid", 128'(bus.OutValid), 128'(4'b1011));
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 128'(bus.OutValid), 128'(4'b0000));
        chk("async_reset_outs", outs(), 128'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        @(negedge clk);
        bus.In = 32'd5;
        bus.Sel = 2'd1;
        bus.InValid = 1'b1;
        bus.OutAck = '0;
        #1;
        chk("ow_first_ready", 128'(bus.InReady), 128'd1);
        @(posedge clk);
        #1;
        chk("ow_first_out2", 128'(bus.Out2), 128'd5);
        chk("ow_first_valid", 128'(bus.OutValid), 128'(4'b0010));
        @(negedge clk);
        bus.In = 32'd6;
        #1;
        chk("ow_second_ready", 128'(bus.InReady), 128'(OVW));
        @(posedge clk);
        #1;
        chk("ow_second_out2", 128'(bus.Out2), OVW ? 128'd6 : 128'd5);
        chk("ow_second_ovf", 128'(bus.Ovf), 128'(OVW));
        chk("ow_second_valid", 128'(bus.OutValid), 128'(4'b0010));
        @(negedge clk);
        bus.OutAck = 4'b0010;
        #1;
        chk("ow_ack_ready", 128'(bus.InReady), 128'd1);
        @(posedge clk);
        #1;
        chk("ow_ack_out2", 128'(bus.Out2), 128'd6);
        chk("ow_ack_valid", 128'(bus.OutValid), 128'(4'b0010));
        @(negedge clk);
        bus.InValid = 1'b0;
        bus.OutAck = 4'b0010;
        @(posedge clk);
        #1;
        chk("ow_drain_valid", 128'(bus.OutValid), 128'(4'b0000));
        chk("ow_drain_out2", 128'(bus.Out2), 128'd6);
        @(negedge clk);
        bus.OutAck = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("ow_sticky_ovf", 128'(bus.Ovf), 128'(OVW));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ow_reset_ovf", 128'(bus.Ovf), 128'd0);
        chk("ow_reset_outs", outs(), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
